// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: sequencer feeding operands to an external 3-bit ripple-carry adder
//   clk/rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data    operand words, A then B
//   in_cin                       carry-in, taken with B only
//   chain_en                     in IDLE: reuse previous sum as A, word is B
//   add_a/add_b/add_cin          registered adder operands
//   add_sum/add_cout             adder result (combinational from add_*)
//   res_valid/res_ready/res_data result word {ovf, sum}
//   op_count                     completed result handshakes, wraps
//   Define RCA_SEQ_SAT_EN to saturate to 4'b1111 on carry-out.
module rca_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_data,
  input  logic       in_cin,
  input  logic       chain_en,
  output logic [2:0] add_a,
  output logic [2:0] add_b,
  output logic       add_cin,
  input  logic [2:0] add_sum,
  input  logic       add_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, GOT_A, ADD, OUT} state_t;
  state_t     state, nxt;
  logic [2:0] prev_sum;
  logic [3:0] res_nxt;
  logic       take_a, take_b, done;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE  ? (in_valid ? (chain_en ? ADD : GOT_A) : IDLE) :
          state == GOT_A ? (in_valid ? ADD : GOT_A) :
          state == ADD   ? OUT :
                           (res_ready ? IDLE : OUT);
  always_comb begin
    in_ready  = state == IDLE || state == GOT_A;
    res_valid = state == OUT;
    take_a    = in_valid && state == IDLE && !chain_en;
    take_b    = in_valid && (state == GOT_A || (state == IDLE && chain_en));
    done      = res_valid && res_ready;
  end
`ifdef RCA_SEQ_SAT_EN
  always_comb res_nxt = add_cout ? 4'b1111 : {1'b0, add_sum};
`else
  always_comb res_nxt = {add_cout, add_sum};
`endif
  always_ff @(posedge clk)
    if (rst) begin
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      res_data <= '0;
      prev_sum <= '0;
      op_count <= '0;
    end else begin
      if (take_a) add_a <= in_data;
      if (take_b) begin
        add_b   <= in_data;
        add_cin <= in_cin;
        if (state == IDLE) add_a <= prev_sum;
      end
      if (state == ADD) res_data <= res_nxt;
      if (done) begin
        op_count <= op_count + 8'd1;
        prev_sum <= res_data[2:0];
      end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed and randomized checks of rca_seq_ctrl against an arithmetic model
module tb_rca_seq_ctrl;
  logic       clk = 0, rst = 1, in_valid = 0, in_cin = 0, chain_en = 0, res_ready = 0;
  logic [2:0] in_data = 0, add_a, add_b, add_sum;
  logic       in_ready, add_cin, add_cout, res_valid;
  logic [3:0] res_data;
  logic [7:0] op_count;
  int         n = 0, err = 0, m_cnt = 0;
  logic [2:0] m_prev = 0;

  rca_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cin(in_cin), .chain_en(chain_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .op_count(op_count)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  task automatic do_reset(input logic iv);
    @(negedge clk);
    rst = 1; in_valid = iv; in_data = 3'd6; res_ready = iv;
    @(posedge clk);
    @(negedge clk);
    rst = 0; in_valid = 0; res_ready = 0;
    chk_idle();
    m_cnt = 0; m_prev = 0;
  endtask

  task automatic op(input logic [2:0] a, b, input logic c, ch, input int hold, gap);
    logic [2:0] ea;
    logic [3:0] exp;
    int s;
    ea = ch ? m_prev : a;
    s = int'(ea) + int'(b) + int'(c);
`ifdef RCA_SEQ_SAT_EN
    exp = s > 7 ? 4'b1111 : 4'(s);
`else
    exp = 4'(s);
`endif
    if (!ch) begin
      @(negedge clk);
      chk("a_in_ready", in_ready, 1);
      in_valid = 1; in_data = a; chain_en = 0; in_cin = 1'($urandom);
      @(posedge clk);
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        in_valid = 0; in_data = 3'($urandom);
        chk("gota_in_ready", in_ready, 1);
        @(posedge clk);
      end
    end
    @(negedge clk);
    chk("b_in_ready", in_ready, 1);
    in_valid = 1; in_data = b; in_cin = c; chain_en = ch ? 1'b1 : 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'($urandom); in_data = 3'($urandom); in_cin = 1'($urandom); chain_en = 1'($urandom);
    chk("add_in_ready", in_ready, 0);
    chk("add_res_valid", res_valid, 0);
    chk("add_a", add_a, ea);
    chk("add_b", add_b, b);
    chk("add_cin", add_cin, c);
    @(posedge clk);
    @(negedge clk);
    chk("out_res_valid", res_valid, 1);
    chk("out_res_data", res_data, exp);
    for (int i = 0; i < hold; i++) begin
      res_ready = 0; in_valid = 1'($urandom); in_data = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_op_count", op_count, 8'(m_cnt));
      chk("hold_add_a", add_a, ea);
    end
    res_ready = 1; in_valid = 1'($urandom);
    @(posedge clk);
    m_cnt = (m_cnt + 1) % 256;
    m_prev = exp[2:0];
    @(negedge clk);
    in_valid = 0;
    chk("post_op_count", op_count, 8'(m_cnt));
    chk("post_res_valid", res_valid, 0);
    chk("post_in_ready", in_ready, 1);
    res_ready = 1'($urandom);
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_idle();
    rst = 0;
    op(3'd3, 3'd2, 1'b0, 1'b0, 0, 0);
    op(3'd7, 3'd1, 1'b0, 1'b0, 0, 1);
    op(3'd2, 3'd2, 1'b1, 1'b0, 5, 0);
    op(3'd1, 3'd2, 1'b0, 1'b0, 0, 0);
    op(3'd0, 3'd3, 1'b1, 1'b1, 0, 0);
    @(negedge clk);
    in_valid = 1; in_data = 3'd5; chain_en = 0; res_ready = 0;
    @(posedge clk);
    do_reset(1'b1);
    op(3'd1, 3'd1, 1'b0, 1'b0, 0, 0);
    do_reset(1'b0);
    op(3'd0, 3'd3, 1'b0, 1'b1, 1, 0);
    @(negedge clk);
    in_valid = 1; in_data = 3'd4; chain_en = 1; in_cin = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    do_reset(1'b1);
    op(3'd0, 3'd2, 1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 40; k++)
      op(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    do_reset(1'b0);
    for (int k = 0; k < 256; k++)
      op(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    chk("wrap_op_count", op_count, 8'(m_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
